// File: rtl/handshake_demux_if.sv
// handshake_demux_if: one input handshake stream plus OUTPUTPORTCOUNT output handshake ports.
// slave is the demux side; master is the producer/consumer side.
interface handshake_demux_if #(
   parameter int DATABITWIDTH    = 16,
   parameter int OUTPUTPORTCOUNT = 4,
   parameter int PORTADDRWIDTH   = 2,
   parameter int REGADDRBITWIDTH = 4
);
   logic                                            InputACK;
   logic                                            InputREQ;
   logic [DATABITWIDTH-1:0]                         InputData;
   logic [REGADDRBITWIDTH-1:0]                      InputAddr;
   logic [PORTADDRWIDTH-1:0]                        InputPort;
   logic [OUTPUTPORTCOUNT-1:0]                      OutputACK;
   logic [OUTPUTPORTCOUNT-1:0]                      OutputREQ;
   logic [OUTPUTPORTCOUNT-1:0][DATABITWIDTH-1:0]    OutputData;
   logic [OUTPUTPORTCOUNT-1:0][REGADDRBITWIDTH-1:0] OutputAddr;
   modport master (
      output InputACK, InputData, InputAddr, InputPort, OutputREQ,
      input  InputREQ, OutputACK, OutputData, OutputAddr
   );
   modport slave (
      input  InputACK, InputData, InputAddr, InputPort, OutputREQ,
      output InputREQ, OutputACK, OutputData, OutputAddr
   );
endinterface

// File: rtl/handshake_demux.sv
// handshake_demux: routes one REQ/ACK stream to per-port 2-entry FIFOs selected by InputPort.
// Define HANDSHAKEDEMUX_DROPCOUNT_EN to add the saturating DropCount for out-of-range ports.
module handshake_demux #(
   parameter int DATABITWIDTH    = 16,
   parameter int OUTPUTPORTCOUNT = 4,
   parameter int PORTADDRWIDTH   = 2,
   parameter int REGADDRBITWIDTH = 4
) (
   input  logic clk,
   input  logic clk_en,
   input  logic sync_rst,
`ifdef HANDSHAKEDEMUX_DROPCOUNT_EN
   output logic [15:0] DropCount,
`endif
   handshake_demux_if.slave bus
);
   logic [DATABITWIDTH-1:0]    data_q [OUTPUTPORTCOUNT][2];
   logic [REGADDRBITWIDTH-1:0] addr_q [OUTPUTPORTCOUNT][2];
   logic [1:0]                 cnt_q  [OUTPUTPORTCOUNT];
   logic [1:0]                 cnt_d  [OUTPUTPORTCOUNT];
   logic [OUTPUTPORTCOUNT-1:0] wp_q, rp_q, push, pop, oack;
   logic                       sel_full, in_req, xfer_in;

   // Out-of-range ports never match a full flag, so they are always accepted and discarded.
   always_comb begin
      sel_full = 1'b0;
      for (int p = 0; p < OUTPUTPORTCOUNT; p++)
         sel_full = sel_full | (int'(bus.InputPort) == p && cnt_q[p] == 2'd2);
      in_req  = clk_en & ~sync_rst & ~sel_full;
      xfer_in = bus.InputACK & in_req;
      push = '0;
      pop  = '0;
      oack = '0;
      for (int p = 0; p < OUTPUTPORTCOUNT; p++) begin
         push[p] = xfer_in && int'(bus.InputPort) == p;
         oack[p] = clk_en && cnt_q[p] != 2'd0;
         pop[p]  = oack[p] & bus.OutputREQ[p];
         cnt_d[p] = cnt_q[p] + {1'b0, push[p]} - {1'b0, pop[p]};
         bus.OutputData[p] = data_q[p][rp_q[p]];
         bus.OutputAddr[p] = addr_q[p][rp_q[p]];
      end
      bus.InputREQ  = in_req;
      bus.OutputACK = oack;
   end

   always_ff @(posedge clk) begin
      if (sync_rst) begin
         wp_q <= '0;
         rp_q <= '0;
         for (int p = 0; p < OUTPUTPORTCOUNT; p++) cnt_q[p] <= 2'd0;
      end else begin
         wp_q <= wp_q ^ push;
         rp_q <= rp_q ^ pop;
         for (int p = 0; p < OUTPUTPORTCOUNT; p++) begin
            cnt_q[p] <= cnt_d[p];
            if (push[p]) begin
               data_q[p][wp_q[p]] <= bus.InputData;
               addr_q[p][wp_q[p]] <= bus.InputAddr;
            end
         end
      end
   end

`ifdef HANDSHAKEDEMUX_DROPCOUNT_EN
   logic [15:0] drop_q, drop_d;
   always_comb
      drop_d = (xfer_in && int'(bus.InputPort) >= OUTPUTPORTCOUNT && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
   always_ff @(posedge clk)
      drop_q <= sync_rst ? 16'd0 : drop_d;
   assign DropCount = drop_q;
`endif
endmodule
